matmul_result_serializer: RTL and testbench

MATMUL_RESULT_SERIALIZER -- requirements
Module: matmul_result_serializer

---
 rtl/matmul_result_serializer.sv | 86 ++++++++
 tb/tb_matmul_result_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_serializer.sv
// Captures an M x N result matrix and streams it row-major, one element per ready_i cycle.
// First element one cycle after accept; ready_i low freezes outputs; back-to-back frames with no bubble.
module matmul_result_serializer #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int DW = 32,
  localparam int RW = (M > 1) ? $clog2(M) : 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] D_i [M][N],
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic signed [DW-1:0] data_o,
  output logic [RW-1:0]        row_o,
  output logic [CW-1:0]        col_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 ready_i,
  output logic [15:0]          frame_cnt_o
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

  state_t               state_q, state_d;
  logic signed [DW-1:0] buf_q [M][N];
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic [15:0]          frame_cnt_q;
  logic                 at_last;
  logic                 accept;
  logic                 xfer;

  assign valid_o     = (state_q == STREAM);
  assign at_last     = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign last_o      = valid_o && at_last;
  // Only input-to-output path: a new frame may enter on the edge that drains the final element.
  assign ready_o     = !valid_o || (last_o && ready_i);
  assign accept      = valid_i && ready_o;
  assign xfer        = valid_o && ready_i;
  assign row_o       = row_q;
  assign col_o       = col_q;
  assign data_o      = valid_o ? buf_q[row_q][col_q] : '0;
  assign frame_cnt_o = frame_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (xfer && last_o && !accept) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        if (at_last) begin
          row_q <= '0;
          col_q <= '0;
          if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
        end else if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // Indices always rest at (0,0) outside a frame, so an accept only needs to load the buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) buf_q <= D_i;
  end

endmodule

// File: tb/tb_matmul_result_serializer.sv
// Randomized and directed checks of the serializer against a queue-based frame model.
module tb_matmul_result_serializer;

  logic clk;
  logic rst;

  // 2x2 instance
  logic signed [31:0] d [2][2];
  logic               vin, rin;
  logic               rdy, vout, last;
  logic signed [31:0] data;
  logic [0:0]         row, col;
  logic [15:0]        fcnt;

  // 3x1 instance
  logic signed [31:0] d2 [3][1];
  logic               v2, r2;
  logic               rdy2, vout2, last2;
  logic signed [31:0] data2;
  logic [1:0]         row2;
  logic [0:0]         col2;
  logic [15:0]        fcnt2;

  matmul_result_serializer #(.M(2), .N(2), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst), .D_i(d), .valid_i(vin), .ready_o(rdy),
    .data_o(data), .row_o(row), .col_o(col), .valid_o(vout), .last_o(last),
    .ready_i(rin), .frame_cnt_o(fcnt)
  );

  matmul_result_serializer #(.M(3), .N(1), .DW(32)) dut31 (
    .clk_i(clk), .rst_i(rst), .D_i(d2), .valid_i(v2), .ready_o(rdy2),
    .data_o(data2), .row_o(row2), .col_o(col2), .valid_o(vout2), .last_o(last2),
    .ready_i(r2), .frame_cnt_o(fcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        r;
    logic        c;
    logic        last;
  } elem_t;

  // Model: queue of elements still owed downstream; the current frame is the only content.
  elem_t       q[$];
  int unsigned mcnt;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (q.size() == 0) || (q.size() == 1 && rin);
  endfunction

  task automatic check_outputs();
    chk("valid_o", 32'(vout), 32'(q.size() != 0));
    chk("ready_o", 32'(rdy), 32'(model_ready()));
    chk("frame_cnt_o", 32'(fcnt), mcnt);
    if (q.size() != 0) begin
      chk("data_o", data, q[0].data);
      chk("row_o", 32'(row), 32'(q[0].r));
      chk("col_o", 32'(col), 32'(q[0].c));
      chk("last_o", 32'(last), 32'(q[0].last));
    end else begin
      chk("last_o_idle", 32'(last), 32'd0);
    end
  endtask

  task automatic model_edge();
    logic  acc;
    elem_t e;
    acc = vin && model_ready();
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (q.size() != 0 && rin) begin
        e = q.pop_front();
        if (e.last && mcnt != 32'd65535) mcnt++;
      end
      if (acc) begin
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 2; c++) begin
            e.data = d[r][c];
            e.r    = 1'(r);
            e.c    = 1'(c);
            e.last = (r == 1) && (c == 1);
            q.push_back(e);
          end
        end
      end
    end
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_mat(input int a, input int b, input int c, input int e);
    d[0][0] = a; d[0][1] = b; d[1][0] = c; d[1][1] = e;
  endtask

  logic [31:0] exp31 [3];

  initial begin
    tests = 0; fails = 0; mcnt = 0;
    rst = 1'b1; vin = 1'b0; rin = 1'b1; set_mat(0, 0, 0, 0);
    v2 = 1'b0; r2 = 1'b1; d2[0][0] = 0; d2[1][0] = 0; d2[2][0] = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    chk("rst_data_o", data, 32'd0);
    chk("rst_row_o", 32'(row), 32'd0);
    chk("rst_col_o", 32'(col), 32'd0);
    @(negedge clk);

    // single frame, ready held high
    set_mat(1, 2, 3, 4); vin = 1'b1; rin = 1'b1;
    step();
    vin = 1'b0;
    repeat (5) step();

    // ready toggling 1,0,0,1,...
    vin = 1'b1;
    step();
    vin = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rin = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    rin = 1'b1;
    step();

    // two frames back to back, valid held high
    set_mat(1, 2, 3, 4); vin = 1'b1;
    step();
    set_mat(-5, 6, 7, -8);
    repeat (4) step();
    vin = 1'b0;
    repeat (5) step();

    // valid pulse with other data mid-stream
    set_mat(1, 2, 3, 4); vin = 1'b1;
    step();
    set_mat(99, 98, 97, 96);
    step();
    vin = 1'b0;
    repeat (4) step();

    // reset after two elements
    set_mat(1, 2, 3, 4); vin = 1'b1;
    step();
    vin = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_data_o", data, 32'd0);
    chk("rst_mid_row_o", 32'(row), 32'd0);
    chk("rst_mid_col_o", 32'(col), 32'd0);
    @(negedge clk);
    set_mat(9, 9, 9, 9); vin = 1'b1;
    step();
    vin = 1'b0;
    repeat (5) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      vin = 1'(($urandom_range(0, 1)));
      rin = ($urandom_range(0, 9) < 6);
      set_mat(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      step();
    end
    rst = 1'b0; vin = 1'b0; rin = 1'b1;
    repeat (6) step();

    // 3x1 column matrix
    exp31[0] = 32'hFFFF_FFFF; exp31[1] = 32'd0; exp31[2] = 32'h7FFF_FFFF;
    d2[0][0] = -1; d2[1][0] = 0; d2[2][0] = 32'sh7FFF_FFFF;
    v2 = 1'b1;
    step();
    v2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("m31_valid_o", 32'(vout2), 32'd1);
      chk("m31_data_o", data2, exp31[i]);
      chk("m31_row_o", 32'(row2), i);
      chk("m31_col_o", 32'(col2), 32'd0);
      chk("m31_last_o", 32'(last2), 32'(i == 2));
      chk("m31_ready_o", 32'(rdy2), 32'(i == 2));
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("m31_valid_end", 32'(vout2), 32'd0);
    chk("m31_frame_cnt", 32'(fcnt2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
